load_store_unit: RTL and testbench

Memory-access stage of the RV32 core, directly upstream of the load data extender. Accepts one load or store at a time from execute, validates alignment, drives the data-memory request/grant/valid bus with byte enables, and returns load data right-aligned with the `readEnable`/`mode` controls the extender consumes. It stalls the pipeline through a ready/valid handshake while an access is in flight.

---
 rtl/load_store_unit.sv | 164 ++++++++++++++++
 tb/tb_load_store_unit.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Memory-access stage: accepts one load/store at a time, checks alignment, drives the
// request/grant/valid data bus and returns right-aligned load data with extender controls.
module load_store_unit #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              is_store_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       store_data_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_be_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i,
    output logic              rsp_valid_o,
    output logic              rsp_err_o,
    output logic [31:0]       data_out_o,
    output logic [2:0]        read_enable_o,
    output logic              mode_o
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e            state_q;
    logic              req_ready_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [3:0]        mem_be_q;
    logic [31:0]       mem_wdata_q;
    logic [1:0]        off_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [31:0]       data_out_q;
    logic [2:0]        read_enable_q;
    logic              mode_q;

    // Bus fields for the incoming request, captured only on acceptance
    logic        acc_err_d;
    logic [3:0]  acc_be_d;
    logic [31:0] acc_wdata_d;
    logic [2:0]  acc_re_d;
    logic [1:0]  off_d;

    assign off_d = addr_i[1:0];

    // Decode width, alignment, lane enables and replicated store data from the request
    always_comb begin
        acc_err_d   = 1'b0;
        acc_be_d    = 4'b0000;
        acc_wdata_d = store_data_i;
        acc_re_d    = 3'b000;
        case (funct3_i)
            3'b000, 3'b100: begin
                acc_be_d    = 4'b0001 << off_d;
                acc_wdata_d = {4{store_data_i[7:0]}};
                acc_re_d    = 3'b001;
            end
            3'b001, 3'b101: begin
                acc_err_d   = off_d[0];
                acc_be_d    = 4'b0011 << off_d;
                acc_wdata_d = {2{store_data_i[15:0]}};
                acc_re_d    = 3'b011;
            end
            3'b010: begin
                acc_err_d = (off_d != 2'b00);
                acc_be_d  = 4'b1111;
                acc_re_d  = 3'b111;
            end
            default: acc_err_d = 1'b1;
        endcase
        // A rejected access never reaches the bus, so it enables no lanes
        if (acc_err_d) begin
            acc_be_d = 4'b0000;
        end
    end

    // Access FSM with all outputs registered; rsp_valid is high only in the DONE cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            req_ready_q   <= 1'b1;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_be_q      <= 4'b0000;
            mem_wdata_q   <= 32'h0;
            off_q         <= 2'b00;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            data_out_q    <= 32'h0;
            read_enable_q <= 3'b000;
            mode_q        <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        req_ready_q   <= 1'b0;
                        mem_we_q      <= is_store_i & ~acc_err_d;
                        mem_addr_q    <= {addr_i[ADDR_W-1:2], 2'b00};
                        mem_be_q      <= acc_be_d;
                        mem_wdata_q   <= acc_wdata_d;
                        off_q         <= off_d;
                        read_enable_q <= acc_re_d;
                        mode_q        <= ~funct3_i[2];
                        if (acc_err_d) begin
                            state_q     <= StDone;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else begin
                            state_q   <= StReq;
                            mem_req_q <= 1'b1;
                        end
                    end
                end
                StReq: begin
                    if (mem_gnt_i) begin
                        mem_req_q <= 1'b0;
                        if (mem_we_q) begin
                            state_q     <= StDone;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (mem_rvalid_i) begin
                        data_out_q  <= mem_rdata_i >> {off_q, 3'b000};
                        state_q     <= StDone;
                        rsp_valid_q <= 1'b1;
                    end
                end
                StDone: begin
                    state_q     <= StIdle;
                    req_ready_q <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready_o   = req_ready_q;
    assign mem_req_o     = mem_req_q;
    assign mem_we_o      = mem_we_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_be_o      = mem_be_q;
    assign mem_wdata_o   = mem_wdata_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_err_o     = rsp_err_q;
    assign data_out_o    = data_out_q;
    assign read_enable_o = read_enable_q;
    assign mode_o        = mode_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table plus reset and back-to-back sequences,
// with responses checked against a scoreboard queue.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] data_out;
    logic [2:0]  read_enable;
    logic        mode;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .is_store_i   (is_store),
        .funct3_i     (funct3),
        .addr_i       (addr),
        .store_data_i (store_data),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_be_o     (mem_be),
        .mem_wdata_o  (mem_wdata),
        .mem_gnt_i    (mem_gnt),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata),
        .rsp_valid_o  (rsp_valid),
        .rsp_err_o    (rsp_err),
        .data_out_o   (data_out),
        .read_enable_o(read_enable),
        .mode_o       (mode)
    );

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rd;
        int          gdly;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        err;
        logic [31:0] dout;
        logic [2:0]  re;
        logic        chk_re;
        logic        mode;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] dout;
        logic [2:0]  re;
        logic        chk_re;
        logic        mode;
    } rsp_t;

    rsp_t sb[$];
    rsp_t mon_e;
    vec_t vecs[10];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Every completion pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response");
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_err", {31'h0, rsp_err}, {31'h0, mon_e.err});
                chk("data_out", data_out, mon_e.dout);
                chk("mode", {31'h0, mode}, {31'h0, mon_e.mode});
                if (mon_e.chk_re) chk("read_enable", {29'h0, read_enable}, {29'h0, mon_e.re});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, {31'h0, req_ready}, 32'h1);
        chk({tag, "_mem_req"}, {31'h0, mem_req}, 32'h0);
        chk({tag, "_mem_we"}, {31'h0, mem_we}, 32'h0);
        chk({tag, "_mem_addr"}, mem_addr, 32'h0);
        chk({tag, "_mem_be"}, {28'h0, mem_be}, 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        chk({tag, "_rsp_valid"}, {31'h0, rsp_valid}, 32'h0);
        chk({tag, "_rsp_err"}, {31'h0, rsp_err}, 32'h0);
        chk({tag, "_data_out"}, data_out, 32'h0);
        chk({tag, "_read_enable"}, {29'h0, read_enable}, 32'h0);
        chk({tag, "_mode"}, {31'h0, mode}, 32'h0);
    endtask

    // Drives one access at a negedge in IDLE and follows it to completion
    task automatic run_vec(input vec_t v);
        rsp_t e;
        e = '{v.err, v.dout, v.re, v.chk_re, v.mode};
        chk("req_ready_idle", {31'h0, req_ready}, 32'h1);
        is_store   = v.st;
        funct3     = v.f3;
        addr       = v.addr;
        store_data = v.sd;
        req_valid  = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        chk("req_ready_busy", {31'h0, req_ready}, 32'h0);
        if (v.err) begin
            chk("err_rsp_cycle1", {31'h0, rsp_valid}, 32'h1);
            chk("err_no_req", {31'h0, mem_req}, 32'h0);
            chk("err_be", {28'h0, mem_be}, 32'h0);
            @(negedge clk);
            chk("err_no_req_after", {31'h0, mem_req}, 32'h0);
            chk("err_ready_after", {31'h0, req_ready}, 32'h1);
            return;
        end
        for (int i = 0; i <= v.gdly; i++) begin
            chk("mem_req", {31'h0, mem_req}, 32'h1);
            chk("mem_addr", mem_addr, {v.addr[31:2], 2'b00});
            chk("mem_be", {28'h0, mem_be}, {28'h0, v.be});
            chk("mem_we", {31'h0, mem_we}, {31'h0, v.st});
            if (v.st) chk("mem_wdata", mem_wdata, v.wd);
            chk("rsp_early_req", {31'h0, rsp_valid}, 32'h0);
            if (i == v.gdly) mem_gnt = 1'b1;
            @(negedge clk);
        end
        mem_gnt = 1'b0;
        chk("mem_req_dropped", {31'h0, mem_req}, 32'h0);
        if (!v.st) begin
            chk("rsp_early_wait", {31'h0, rsp_valid}, 32'h0);
            chk("req_ready_wait", {31'h0, req_ready}, 32'h0);
            mem_rvalid = 1'b1;
            mem_rdata  = v.rd;
            @(negedge clk);
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h0;
        end
        chk("rsp_cycle", {31'h0, rsp_valid}, 32'h1);
        chk("req_ready_done", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        chk("rsp_one_cycle", {31'h0, rsp_valid}, 32'h0);
        chk("req_ready_back", {31'h0, req_ready}, 32'h1);
    endtask

    initial begin
        // st f3 addr sd rd gdly be wd err dout re chk_re mode
        vecs[0] = '{1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 4'b1111, 32'h0,
                    1'b0, 32'hDEADBEEF, 3'b111, 1'b1, 1'b1};
        vecs[1] = '{1'b0, 3'b100, 32'h203, 32'h0, 32'h80AABBCC, 0, 4'b1000, 32'h0,
                    1'b0, 32'h00000080, 3'b001, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 3'b001, 32'h12, 32'h0000A5C3, 32'h0, 3, 4'b1100, 32'hA5C3A5C3,
                    1'b0, 32'h00000080, 3'b011, 1'b1, 1'b1};
        vecs[3] = '{1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 4'b0000, 32'h0,
                    1'b1, 32'h00000080, 3'b111, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 3'b000, 32'h102, 32'h0, 32'h12345678, 1, 4'b0100, 32'h0,
                    1'b0, 32'h00001234, 3'b001, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 3'b101, 32'h42, 32'h0, 32'hF00DCAFE, 0, 4'b1100, 32'h0,
                    1'b0, 32'h0000F00D, 3'b011, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 3'b000, 32'h7, 32'h000000AB, 32'h0, 0, 4'b1000, 32'hABABABAB,
                    1'b0, 32'h0000F00D, 3'b001, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 3'b010, 32'h8, 32'h11223344, 32'h0, 2, 4'b1111, 32'h11223344,
                    1'b0, 32'h0000F00D, 3'b111, 1'b1, 1'b1};
        vecs[8] = '{1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 0, 4'b0000, 32'h0,
                    1'b1, 32'h0000F00D, 3'b000, 1'b0, 1'b1};
        vecs[9] = '{1'b1, 3'b001, 32'h21, 32'h0000BEEF, 32'h0, 0, 4'b0000, 32'h0,
                    1'b1, 32'h0000F00D, 3'b011, 1'b1, 1'b1};

        rst        = 1'b1;
        req_valid  = 1'b0;
        is_store   = 1'b0;
        funct3     = 3'b000;
        addr       = 32'h0;
        store_data = 32'h0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        @(negedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // LH at 0x40, reset while waiting for read data, then a late rvalid
        is_store  = 1'b0;
        funct3    = 3'b001;
        addr      = 32'h40;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_seq_req", {31'h0, mem_req}, 32'h1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("rst_seq_in_wait", {31'h0, mem_req}, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_vals("mid_reset");
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFFFFFF;
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        chk("late_rvalid_dout", data_out, 32'h0);
        chk("late_rvalid_rsp", {31'h0, rsp_valid}, 32'h0);
        run_vec('{1'b0, 3'b010, 32'h44, 32'h0, 32'h0BADF00D, 0, 4'b1111, 32'h0,
                  1'b0, 32'h0BADF00D, 3'b111, 1'b1, 1'b1});

        // Back-to-back loads with req_valid held high
        is_store  = 1'b0;
        funct3    = 3'b010;
        addr      = 32'h300;
        req_valid = 1'b1;
        sb.push_back('{1'b0, 32'hCAFEBABE, 3'b111, 1'b1, 1'b1});
        @(negedge clk);
        chk("b2b_ready_c1", {31'h0, req_ready}, 32'h0);
        chk("b2b_addr1", mem_addr, 32'h300);
        funct3  = 3'b100;
        addr    = 32'h305;
        mem_gnt = 1'b1;
        sb.push_back('{1'b0, 32'h0000007F, 3'b001, 1'b1, 1'b0});
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("b2b_ready_c2", {31'h0, req_ready}, 32'h0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFEBABE;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("b2b_ready_c3", {31'h0, req_ready}, 32'h0);
        chk("b2b_rsp1", {31'h0, rsp_valid}, 32'h1);
        chk("b2b_no_req_done", {31'h0, mem_req}, 32'h0);
        @(negedge clk);
        chk("b2b_ready_c4", {31'h0, req_ready}, 32'h1);
        chk("b2b_no_req_idle", {31'h0, mem_req}, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b_req2", {31'h0, mem_req}, 32'h1);
        chk("b2b_addr2", mem_addr, 32'h304);
        chk("b2b_be2", {28'h0, mem_be}, 32'h2);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h00007F00;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("b2b_rsp2", {31'h0, rsp_valid}, 32'h1);
        @(negedge clk);
        chk("b2b_rsp2_gone", {31'h0, rsp_valid}, 32'h0);

        chk("sb_empty", sb.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
